// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size encodings,
// FSM state encoding, memory map constants and small decode helpers.
package load_store_unit_pkg;

   localparam logic [2:0] LOAD_SIGNED_BYTE   = 3'b000;
   localparam logic [2:0] LOAD_SIGNED_HALF   = 3'b001;
   localparam logic [2:0] LOAD_WORD          = 3'b010;
   localparam logic [2:0] LOAD_UNSIGNED_BYTE = 3'b100;
   localparam logic [2:0] LOAD_UNSIGNED_HALF = 3'b101;

   localparam logic [2:0] STORE_BYTE = 3'b000;
   localparam logic [2:0] STORE_HALF = 3'b001;
   localparam logic [2:0] STORE_WORD = 3'b010;

   localparam logic [31:0] ROM_BASE = 32'h0000_0000;
   localparam logic [31:0] RAM_BASE = 32'h0000_1000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_t;

   // 011, 110 and 111 have no meaning as a size
   function automatic logic size_is_legal(input logic [2:0] s);
      return (s != 3'b011) && (s != 3'b110) && (s != 3'b111);
   endfunction

   function automatic logic is_aligned(input logic [2:0] s, input logic [1:0] a);
      return (s[1:0] == 2'b00) || ((s[1:0] == 2'b01) && !a[0]) || (a == 2'b00);
   endfunction

   // index of the final byte of a split access: 1 for halfword, 3 for word
   function automatic logic [1:0] last_byte_index(input logic [2:0] s);
      return s[1] ? 2'd3 : 2'd1;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and memory-port bundle of the load/store unit.
// master: the unit itself; slave: pipeline plus memory block.
interface load_store_unit_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_is_store;
   logic [2:0]      req_size_and_sign;
   logic [XLEN-1:0] req_address;
   logic [XLEN-1:0] req_store_data;

   logic            resp_valid;
   logic [XLEN-1:0] resp_data;
   logic            resp_error;

   logic [XLEN-1:0] mem_read_address;
   logic [XLEN-1:0] mem_read_data;
   logic            mem_illegal_read_address;
   logic            mem_illegal_write_address;
   logic [2:0]      mem_size_and_sign;
   logic [XLEN-1:0] mem_write_address;
   logic [XLEN-1:0] mem_write_data;
   logic            mem_write_enable;

   modport master (
      input  req_valid, req_is_store, req_size_and_sign, req_address, req_store_data,
      input  mem_read_data, mem_illegal_read_address, mem_illegal_write_address,
      output req_ready, resp_valid, resp_data, resp_error,
      output mem_read_address, mem_size_and_sign, mem_write_address, mem_write_data,
      output mem_write_enable
   );

   modport slave (
      output req_valid, req_is_store, req_size_and_sign, req_address, req_store_data,
      output mem_read_data, mem_illegal_read_address, mem_illegal_write_address,
      input  req_ready, resp_valid, resp_data, resp_error,
      input  mem_read_address, mem_size_and_sign, mem_write_address, mem_write_data,
      input  mem_write_enable
   );
endinterface

// File: rtl/load_extend.sv
// Combinational sign/zero extension of right-aligned load data by funct3.
module load_extend
   import load_store_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      size_and_sign,
   input  logic [XLEN-1:0] raw_data,
   output logic [XLEN-1:0] ext_data
);

   // select the extension rule for the requested size
   always_comb begin
      ext_data = raw_data;
      case (size_and_sign)
         LOAD_SIGNED_BYTE:   ext_data = {{(XLEN-8){raw_data[7]}}, raw_data[7:0]};
         LOAD_SIGNED_HALF:   ext_data = {{(XLEN-16){raw_data[15]}}, raw_data[15:0]};
         LOAD_UNSIGNED_BYTE: ext_data = {{(XLEN-8){1'b0}}, raw_data[7:0]};
         LOAD_UNSIGNED_HALF: ext_data = {{(XLEN-16){1'b0}}, raw_data[15:0]};
         default:            ext_data = raw_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, runs it against the
// data memory and returns an extended result or an error.
// Build option LSU_MISALIGNED_SPLIT_EN: misaligned H/HU/W accesses are split
// into little-endian byte accesses; without it they return an error.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory port driven (one cycle, or one per byte when splitting)
// RESP   | resp_valid pulse with result
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic               clk,
   input logic               rst_n,
   load_store_unit_if.master bus
);

   lsu_state_t      state_q, state_d;
   logic [XLEN-1:0] addr_q, wdata_q, rdata_q, rdata_d;
   logic [2:0]      size_q;
   logic            is_store_q, error_q, error_d;
   logic [XLEN-1:0] ext_in, ext_out;
   logic            accept, size_ok, aligned, mem_err;
`ifdef LSU_MISALIGNED_SPLIT_EN
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [XLEN-1:0] asm_q, asm_d;
   logic            split, last_byte;
`endif

   assign accept  = bus.req_valid && (state_q == IDLE);
   assign size_ok = size_is_legal(size_q);
   assign aligned = is_aligned(size_q, addr_q[1:0]);
   assign mem_err = is_store_q ? bus.mem_illegal_write_address : bus.mem_illegal_read_address;

`ifdef LSU_MISALIGNED_SPLIT_EN
   assign split     = size_ok && !aligned;
   assign last_byte = (byte_cnt_q == last_byte_index(size_q));
   // memory returns each split byte as BU, so it lands at bits [7:0]
   assign asm_d     = asm_q | (XLEN'(bus.mem_read_data[7:0]) << {byte_cnt_q, 3'b000});
   assign ext_in    = split ? asm_d : bus.mem_read_data;
`else
   assign ext_in    = bus.mem_read_data;
`endif

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .size_and_sign (size_q),
      .raw_data      (ext_in),
      .ext_data      (ext_out)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state, memory port and response outputs
   always_comb begin
      state_d                = state_q;
      rdata_d                = rdata_q;
      error_d                = error_q;
      bus.req_ready          = (state_q == IDLE);
      bus.resp_valid         = 1'b0;
      bus.resp_data          = '0;
      bus.resp_error         = 1'b0;
      bus.mem_read_address   = '0;
      bus.mem_write_address  = '0;
      bus.mem_write_data     = '0;
      bus.mem_size_and_sign  = '0;
      bus.mem_write_enable   = 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      byte_cnt_d             = byte_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               state_d = ACCESS;
`ifdef LSU_MISALIGNED_SPLIT_EN
               byte_cnt_d = 2'd0;
`endif
            end
         end
         ACCESS: begin
            bus.mem_read_address  = addr_q;
            bus.mem_write_address = addr_q;
            bus.mem_size_and_sign = size_q;
            state_d = RESP;
            rdata_d = '0;
            error_d = 1'b1;
            if (size_ok && aligned) begin
               bus.mem_write_data   = wdata_q;
               bus.mem_write_enable = is_store_q;
               error_d = mem_err;
               rdata_d = (is_store_q || mem_err) ? '0 : ext_out;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            else if (split) begin
               bus.mem_read_address  = addr_q + XLEN'(byte_cnt_q);
               bus.mem_write_address = addr_q + XLEN'(byte_cnt_q);
               bus.mem_size_and_sign = is_store_q ? STORE_BYTE : LOAD_UNSIGNED_BYTE;
               bus.mem_write_data    = XLEN'(wdata_q[{byte_cnt_q, 3'b000} +: 8]);
               bus.mem_write_enable  = is_store_q;
               error_d = mem_err;
               if (!mem_err && !last_byte) begin
                  state_d    = ACCESS;
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end else if (!mem_err && !is_store_q) begin
                  rdata_d = ext_out;
               end
            end
`endif
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = rdata_q;
            bus.resp_error = error_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // request capture and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= '0;
         is_store_q <= 1'b0;
         rdata_q    <= '0;
         error_q    <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
         byte_cnt_q <= '0;
         asm_q      <= '0;
`endif
      end else begin
         if (accept) begin
            addr_q     <= bus.req_address;
            wdata_q    <= bus.req_store_data;
            size_q     <= bus.req_size_and_sign;
            is_store_q <= bus.req_is_store;
         end
         rdata_q <= rdata_d;
         error_q <= error_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
         byte_cnt_q <= byte_cnt_d;
         if (accept)                 asm_q <= '0;
         else if (state_q == ACCESS) asm_q <= asm_d;
`endif
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte-array memory (ROM 0x000-0x7FF,
// RAM 0x1000-0x1FFF), a reference model of each request, directed cases
// and a randomized sweep.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if #(.XLEN(32)) bus ();
   load_store_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_fail = 0;
   int we_count = 0;

   logic [7:0]  env_mem [0:8191];
   logic [7:0]  ref_mem [0:8191];
   logic        pl_we = 1'b0;
   logic [31:0] pl_addr = '0;
   logic [7:0]  pl_data = '0;
   logic [31:0] env_rdata;
   logic        env_rd_ill, env_wr_ill;
   logic [31:0] last_data;
   logic        last_err;
   int          last_lat;

   function automatic bit rd_ok(input logic [31:0] a);
      return (a < 32'h800) || (a >= RAM_BASE && a < 32'h2000);
   endfunction

   function automatic bit wr_ok(input logic [31:0] a);
      return (a >= RAM_BASE) && (a < 32'h2000);
   endfunction

   function automatic int nbytes(input logic [2:0] s);
      return (s[1:0] == 2'b00) ? 1 : ((s[1:0] == 2'b01) ? 2 : 4);
   endfunction

   function automatic logic [31:0] extend_ref(input logic [31:0] v, input logic [2:0] s);
      case (s)
         3'b000:  return (v >= 32'h80)   ? v - 32'h100     : v;
         3'b001:  return (v >= 32'h8000) ? v - 32'h1_0000  : v;
         default: return v;
      endcase
   endfunction

   // memory block: combinational read, write on the clock edge
   always_comb begin
      env_rdata  = '0;
      env_rd_ill = 1'b0;
      env_wr_ill = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k < nbytes(bus.mem_size_and_sign)) begin
            if (!rd_ok(bus.mem_read_address + 32'(k))) env_rd_ill = 1'b1;
            else env_rdata[8*k +: 8] = env_mem[13'(bus.mem_read_address + 32'(k))];
            if (!wr_ok(bus.mem_write_address + 32'(k))) env_wr_ill = 1'b1;
         end
      end
   end

   assign bus.mem_read_data             = env_rdata;
   assign bus.mem_illegal_read_address  = env_rd_ill;
   assign bus.mem_illegal_write_address = env_wr_ill;

   always @(posedge clk) begin
      if (pl_we) env_mem[pl_addr[12:0]] <= pl_data;
      else if (bus.mem_write_enable && !env_wr_ill)
         for (int k = 0; k < 4; k++)
            if (k < nbytes(bus.mem_size_and_sign))
               env_mem[13'(bus.mem_write_address + 32'(k))] <= bus.mem_write_data[8*k +: 8];
      if (bus.mem_write_enable) we_count <= we_count + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = b;
      ref_mem[a[12:0]] = b;
   endtask

   task automatic preload_done();
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   // reference: result, error, accept-to-resp latency and write strobes (-1: not checked)
   task automatic model(input bit st, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] d, output bit e,
                        output int lat, output int we);
      int n;
      logic [31:0] v;
      bit ok;
      d = '0; e = 1'b0; lat = 2; we = 0; v = '0;
      if (sz == 3'b011 || sz == 3'b110 || sz == 3'b111) begin
         e = 1'b1;
         return;
      end
      n = nbytes(sz);
      if ((a & 32'(n - 1)) != 0) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
         for (int k = 0; k < n; k++) begin
            logic [31:0] ba;
            ba = a + 32'(k);
            if (!(st ? wr_ok(ba) : rd_ok(ba))) begin
               e = 1'b1; lat = k + 2; we = -1;
               return;
            end
            if (st) begin
               ref_mem[ba[12:0]] = wd[8*k +: 8];
               we++;
            end else begin
               v = v | (32'(ref_mem[ba[12:0]]) << (8*k));
            end
         end
         lat = n + 1;
`else
         e = 1'b1;
         return;
`endif
      end else begin
         ok = 1'b1;
         for (int k = 0; k < n; k++)
            if (!(st ? wr_ok(a + 32'(k)) : rd_ok(a + 32'(k)))) ok = 1'b0;
         we = st ? 1 : 0;
         if (!ok) begin
            e = 1'b1;
            return;
         end
         for (int k = 0; k < n; k++) begin
            if (st) ref_mem[13'(a + 32'(k))] = wd[8*k +: 8];
            else    v = v | (32'(ref_mem[13'(a + 32'(k))]) << (8*k));
         end
      end
      if (!st) d = extend_ref(v, sz);
   endtask

   task automatic run_req(input bit st, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
      logic [31:0] ed;
      bit ee;
      int el, ew, we0, lat;
      model(st, sz, a, wd, ed, ee, el, ew);
      @(negedge clk);
      check_val("ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid         = 1'b1;
      bus.req_is_store      = st;
      bus.req_size_and_sign = sz;
      bus.req_address       = a;
      bus.req_store_data    = wd;
      we0 = we_count;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_val("ready_busy", 32'(bus.req_ready), 32'd0);
      lat = 1;
      while (!bus.resp_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      last_data = bus.resp_data;
      last_err  = bus.resp_error;
      last_lat  = lat;
      check_val("latency", 32'(lat), 32'(el));
      check_val("resp_data", bus.resp_data, ed);
      check_val("resp_error", 32'(bus.resp_error), 32'(ee));
      @(negedge clk);
      check_val("resp_pulse", 32'(bus.resp_valid), 32'd0);
      if (ew >= 0) check_val("write_strobes", 32'(we_count - we0), 32'(ew));
   endtask

   initial begin
      logic [31:0] bd [3];
      bit          be [3];
      bit          bst [3];
      logic [2:0]  bsz [3];
      logic [31:0] bad [3];
      logic [31:0] bwd [3];
      int          acc_t [3];
      int          bl, bw, idx, nresp;
      bit          adv;
      logic [31:0] a;
      logic [31:0] rv;

      bus.req_valid = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_size_and_sign = '0;
      bus.req_address = '0;
      bus.req_store_data = '0;

      for (int i = 0; i < 256; i++) preload(32'h1000 + 32'(i), 8'($urandom));
      for (int i = 0; i < 256; i++) preload(32'(i), 8'($urandom));
      for (int i = 0; i < 16; i++)  preload(32'h7F0 + 32'(i), 8'($urandom));
      preload_done();

      check_val("rst_ready", 32'(bus.req_ready), 32'd1);
      check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check_val("rst_resp_data", bus.resp_data, 32'd0);
      check_val("rst_resp_error", 32'(bus.resp_error), 32'd0);
      check_val("rst_we", 32'(bus.mem_write_enable), 32'd0);
      check_val("rst_raddr", bus.mem_read_address, 32'd0);
      check_val("rst_waddr", bus.mem_write_address, 32'd0);
      check_val("rst_wdata", bus.mem_write_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // sign and zero extension of a byte
      preload(32'h1000, 8'h80);
      preload(32'h1001, 8'h00);
      preload(32'h1002, 8'h00);
      preload(32'h1003, 8'h00);
      preload_done();
      run_req(1'b0, LOAD_SIGNED_BYTE, 32'h1000, 32'h0);
      check_val("lb_value", last_data, 32'hFFFF_FF80);
      check_val("lb_latency", 32'(last_lat), 32'd2);
      run_req(1'b0, LOAD_UNSIGNED_BYTE, 32'h1000, 32'h0);
      check_val("lbu_value", last_data, 32'h0000_0080);

      // store then halfword load of the upper half
      run_req(1'b1, STORE_WORD, 32'h1004, 32'hDEAD_BEEF);
      check_val("sw_data_zero", last_data, 32'd0);
      run_req(1'b0, LOAD_UNSIGNED_HALF, 32'h1006, 32'h0);
      check_val("lhu_value", last_data, 32'h0000_DEAD);

      // illegal addresses
      run_req(1'b0, LOAD_WORD, 32'h0000_0800, 32'h0);
      check_val("lw_hole_err", 32'(last_err), 32'd1);
      check_val("lw_hole_data", last_data, 32'd0);
      run_req(1'b1, STORE_WORD, 32'h0, 32'h1234_5678);
      check_val("sw_rom_err", 32'(last_err), 32'd1);

      // misaligned word load over bytes 11 22 33 44 55
      preload(32'h1000, 8'h11);
      preload(32'h1001, 8'h22);
      preload(32'h1002, 8'h33);
      preload(32'h1003, 8'h44);
      preload(32'h1004, 8'h55);
      preload_done();
      run_req(1'b0, LOAD_WORD, 32'h1001, 32'h0);
`ifdef LSU_MISALIGNED_SPLIT_EN
      check_val("mis_lw_data", last_data, 32'h5544_3322);
      check_val("mis_lw_latency", 32'(last_lat), 32'd5);
`else
      check_val("mis_lw_err", 32'(last_err), 32'd1);
      check_val("mis_lw_latency", 32'(last_lat), 32'd2);
`endif
      run_req(1'b1, STORE_WORD, 32'h1011, 32'hCAFE_F00D);
      run_req(1'b0, LOAD_WORD, 32'h1010, 32'h0);
      run_req(1'b0, LOAD_SIGNED_HALF, 32'h1013, 32'h0);

      // reset during the ACCESS cycle of a store
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_is_store = 1'b1;
      bus.req_size_and_sign = STORE_WORD;
      bus.req_address = 32'h1020;
      bus.req_store_data = 32'hA5A5_5A5A;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_val("abort_we_before", 32'(bus.mem_write_enable), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("abort_we_dropped", 32'(bus.mem_write_enable), 32'd0);
      check_val("abort_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_val("abort_no_resp", 32'(bus.resp_valid), 32'd0);
         @(negedge clk);
      end
      run_req(1'b0, LOAD_WORD, 32'h1020, 32'h0);

      // back-to-back requests with req_valid held high
      rv = $urandom;
      bst[0] = 1'b1; bsz[0] = STORE_WORD;       bad[0] = 32'h1080; bwd[0] = rv;
      bst[1] = 1'b0; bsz[1] = LOAD_WORD;        bad[1] = 32'h1080; bwd[1] = 32'h0;
      bst[2] = 1'b0; bsz[2] = LOAD_SIGNED_BYTE; bad[2] = 32'h1083; bwd[2] = 32'h0;
      for (int i = 0; i < 3; i++) begin
         model(bst[i], bsz[i], bad[i], bwd[i], bd[i], be[i], bl, bw);
         acc_t[i] = -100;
      end
      @(negedge clk);
      idx = 0; nresp = 0; adv = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_is_store = bst[0];
      bus.req_size_and_sign = bsz[0];
      bus.req_address = bad[0];
      bus.req_store_data = bwd[0];
      for (int t = 0; t < 30; t++) begin
         if (bus.resp_valid) begin
            if (nresp < 3) begin
               check_val("b2b_data", bus.resp_data, bd[nresp]);
               check_val("b2b_error", 32'(bus.resp_error), 32'(be[nresp]));
            end
            nresp++;
         end
         if (adv) begin
            adv = 1'b0;
            idx++;
            if (idx < 3) begin
               bus.req_is_store = bst[idx];
               bus.req_size_and_sign = bsz[idx];
               bus.req_address = bad[idx];
               bus.req_store_data = bwd[idx];
            end else begin
               bus.req_valid = 1'b0;
            end
         end
         if (bus.req_valid && bus.req_ready && idx < 3) begin
            acc_t[idx] = t;
            adv = 1'b1;
         end
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      check_val("b2b_resp_count", 32'(nresp), 32'd3);
      check_val("b2b_gap_1", 32'(acc_t[1] - acc_t[0]), 32'd3);
      check_val("b2b_gap_2", 32'(acc_t[2] - acc_t[1]), 32'd3);

      // randomized sweep
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0:       a = 32'h1000 + 32'($urandom_range(0, 240));
            1:       a = 32'($urandom_range(0, 240));
            2:       a = 32'h7FC + 32'($urandom_range(0, 7));
            3:       a = 32'hFFC + 32'($urandom_range(0, 7));
            default: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         endcase
         run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
